ram_stream_reader: RTL and testbench

Read-side sequencer for one port of the dual-port `ram` (AW=11, MW=8, DW=8 defaults). On a start command it walks `num_rows` addresses from `start_addr` with a programmable stride and issues one read per cycle. It hides the RAM's one-cycle registered read latency behind a 2-entry skid FIFO and presents the words as a valid/ready stream to the downstream consumer, such as a systolic-array feeder. The write port of the same RAM is owned by a separate writer; this block never writes.

---
 rtl/ram_rd_pkg.sv | 30 +++
 rtl/ram_rd_skid_fifo.sv | 84 ++++++++
 rtl/ram_stream_reader.sv | 156 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_rd_pkg.sv
// Shared definitions for the RAM stream reader.
// Contents:
//   - the sequencer state type
//   - the skid FIFO depth
//   - the RAM read latency
//   - a helper that decides whether another read may be issued without
//     overflowing the skid FIFO
package ram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int RD_FIFO_DEPTH = 2;
  localparam int RAM_RD_LAT    = 1;

  // A read may go out only if every word already committed to the FIFO
  // fits. Committed words are those stored now, plus the one landing from
  // last cycle's read, minus the one leaving this cycle.
  function automatic logic can_issue(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    logic [2:0] load;
    load = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (load < 3'(RD_FIFO_DEPTH));
  endfunction

endpackage

// File: rtl/ram_rd_skid_fifo.sv
// Two-entry skid FIFO that absorbs RAM read data while the consumer stalls.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   push         write push_data this cycle
//   push_data    word to store
//   pop          head word is consumed this cycle
//                (ignored when the FIFO is empty)
//   head_data    oldest stored word; held stable until popped
//   head_valid   FIFO is not empty
//   occupancy    number of stored words, 0..2
module ram_rd_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         head_valid,
  output logic [1:0]   occupancy
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic         pop_s;

  // Next-state logic.
  // Entry 0 is always the head; entry 1 shifts into it on a pop.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    pop_s  = pop && (occ_q != 2'd0);
    case ({push, pop_s})
      2'b10: begin
        if (occ_q == 2'd0) begin
          ent0_d = push_data;
          occ_d  = 2'd1;
        end else if (occ_q == 2'd1) begin
          ent1_d = push_data;
          occ_d  = 2'd2;
        end else begin
          // Full: the issuer never lets this happen, so drop the push.
          occ_d = occ_q;
        end
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_data;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent0_q <= {W{1'b0}};
      ent1_q <= {W{1'b0}};
      occ_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign head_data  = ent0_q;
  assign head_valid = (occ_q != 2'd0);
  assign occupancy  = occ_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read-side sequencer for one port of a dual-port RAM.
// On start it reads num_rows words from start_addr with a fixed stride.
// The words are presented as a valid/ready stream. A two-entry skid FIFO
// hides the RAM's one-cycle registered read latency.
// Ports:
//   start, start_addr, stride, num_rows   command, sampled in IDLE only
//   ram_addr, ram_we, ram_q               RAM read port (ram_we is tied to 0)
//   out_data, out_valid, out_ready        output stream
//   busy                                  sequencer is not IDLE
//   done                                  one-cycle pulse after the last word
//                                         is accepted
module ram_stream_reader
  import ram_rd_pkg::*;
#(
  parameter int AW = 11,
  parameter int MW = 8,
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW-1:0]    stride,
  input  logic [AW:0]      num_rows,
  output logic [AW-1:0]    ram_addr,
  output logic [MW-1:0]    ram_we,
  input  logic [MW*DW-1:0] ram_q,
  output logic [MW*DW-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  localparam logic [AW:0] REM_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] REM_ONE  = {{AW{1'b0}}, 1'b1};

  rd_state_e             state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [AW-1:0]         stride_q, stride_d;
  logic [AW:0]           remaining_q, remaining_d;
  logic [RAM_RD_LAT-1:0] inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  issue_s;
  logic                  pop_s;
  logic [1:0]            fifo_occ_s;
  logic                  fifo_valid_s;
  logic [MW*DW-1:0]      fifo_head_s;

  assign pop_s = fifo_valid_s && out_ready;

  ram_rd_skid_fifo #(.W(MW*DW)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (inflight_q[RAM_RD_LAT-1]),
    .push_data  (ram_q),
    .pop        (pop_s),
    .head_data  (fifo_head_s),
    .head_valid (fifo_valid_s),
    .occupancy  (fifo_occ_s)
  );

  // FSM next state, address generator, remaining counter and status outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    stride_d    = stride_q;
    remaining_d = remaining_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    issue_s     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          stride_d    = stride;
          remaining_d = num_rows;
          busy_d      = 1'b1;
          if (num_rows == REM_ZERO) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        issue_s = (remaining_q != REM_ZERO) &&
                  can_issue(fifo_occ_s, inflight_q[RAM_RD_LAT-1], pop_s);
        if (issue_s) begin
          // ram_addr always shows the address of the next read;
          // wrapping past the top of the RAM is intended.
          addr_d      = addr_q + stride_q;
          remaining_d = remaining_q - REM_ONE;
          if (remaining_q == REM_ONE) begin
            state_d = DRAIN;
          end else begin
            state_d = RUN;
          end
        end else if (remaining_q == REM_ZERO) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        // Finish on the edge that leaves the FIFO empty, so done follows
        // the final acceptance directly.
        if ((inflight_q[RAM_RD_LAT-1] == 1'b0) &&
            ((fifo_occ_s == 2'd0) || ((fifo_occ_s == 2'd1) && pop_s))) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    inflight_d = issue_s;
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= {AW{1'b0}};
      stride_q    <= {AW{1'b0}};
      remaining_q <= REM_ZERO;
      inflight_q  <= {RAM_RD_LAT{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      stride_q    <= stride_d;
      remaining_q <= remaining_d;
      inflight_q  <= inflight_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_we    = {MW{1'b0}};
  assign out_data  = fifo_head_s;
  assign out_valid = fifo_valid_s;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader.
// The RAM is modelled as word_at(addr) with a one-cycle registered read.
// The expected stream for each command is the list of words at
// start + i*stride (mod 2^AW), consumed in order from a queue.
module tb_ram_stream_reader;

  localparam int AW = 11;
  localparam int MW = 8;
  localparam int DW = 8;
  localparam int WW = MW * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] stride;
  logic [AW:0]   num_rows;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_we;
  logic [WW-1:0] ram_q;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;

  ram_stream_reader #(.AW(AW), .MW(MW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .stride     (stride),
    .num_rows   (num_rows),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_q      (ram_q),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [WW-1:0] word_at(input logic [AW-1:0] a);
    return {16'hBEEF, 37'd0, a};
  endfunction

  // RAM read port: data registered on the clock edge after the address.
  always @(posedge clk) ram_q <= word_at(ram_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and check the resulting stream against the model.
  // mode 0: ready always high; 1: ready pattern 1,0,0,1,0,1; 2: random ready.
  // inject: a second start with other parameters arrives mid-run.
  task automatic run_cmd(input logic [AW-1:0] sa, input logic [AW-1:0] st,
                         input logic [AW:0] n, input int mode, input bit inject);
    logic [WW-1:0] expq[$];
    logic [WW-1:0] held;
    logic [5:0]    pat;
    logic [2:0]    ph;
    logic          rdy;
    logic          popping;
    bit            exp_done;
    bit            stalled;
    bit            finished;
    int            budget;
    pat = 6'b101001;  // bit i = ready in phase i: 1,0,0,1,0,1
    for (int i = 0; i < int'(n); i++) begin
      expq.push_back(word_at(AW'(int'(sa) + i * int'(st))));
    end
    start_addr = sa;
    stride     = st;
    num_rows   = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    start_addr = ~sa;
    exp_done   = 1'b0;
    stalled    = 1'b0;
    finished   = 1'b0;
    held       = '0;
    budget     = 100 + 10 * int'(n);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (inject && cyc == 2) begin
        start      = 1'b1;
        start_addr = 11'h3C0;
        stride     = 11'h005;
        num_rows   = 12'd7;
      end else begin
        start = 1'b0;
      end
      if (stalled) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(held));
      end
      check("occ_max2", 64'(dut.fifo_occ_s <= 2'd2), 64'd1);
      check("done", 64'(done), 64'(exp_done));
      if (exp_done) begin
        check("busy_at_done", 64'(busy), 64'd0);
        check("valid_at_done", 64'(out_valid), 64'd0);
        check("words_left", 64'(expq.size()), 64'd0);
        finished = 1'b1;
        break;
      end
      check("busy_run", 64'(busy), 64'd1);
      ph = 3'(cyc % 6);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = pat[ph];
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      popping   = out_valid && rdy;
      exp_done  = 1'b0;
      if (popping) begin
        if (expq.size() == 0) begin
          check("extra_word", 64'(out_data), 64'd0 - 64'd1);
        end else begin
          check("word", 64'(out_data), 64'(expq.pop_front()));
          exp_done = (expq.size() == 0);
        end
      end
      if (n == 12'd0 && cyc == 0) begin
        exp_done = 1'b1;
      end
      stalled = out_valid && !rdy;
      held    = out_data;
      tick();
    end
    start = 1'b0;
    if (!finished) begin
      check("timeout_done", 64'd0, 64'd1);
    end
  endtask

  typedef struct {
    logic          rdy;
    logic          vld;
    logic [AW-1:0] addr;
    logic [WW-1:0] data;
    logic          dn;
    logic          bsy;
  } vec_t;

  vec_t tbl[8];
  int   accepted;

  initial begin
    // Basic stream: start 0x010, stride 1, 4 rows, ready high.
    // Row c is sampled just after the c-th edge following the start edge.
    tbl[0] = '{1'b1, 1'b0, 11'h010, 64'd0,           1'b0, 1'b1};
    tbl[1] = '{1'b1, 1'b0, 11'h011, 64'd0,           1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 11'h012, word_at(11'h010), 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 11'h013, word_at(11'h011), 1'b0, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 11'h014, word_at(11'h012), 1'b0, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 11'h014, word_at(11'h013), 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 11'h014, 64'd0,           1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 11'h014, 64'd0,           1'b0, 1'b0};

    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    stride     = '0;
    num_rows   = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    check("rst_addr", 64'(ram_addr), 64'd0);
    check("rst_we", 64'(ram_we), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    tick();

    // Basic stream, compared cycle by cycle against the table.
    start_addr = 11'h010;
    stride     = 11'h001;
    num_rows   = 12'd4;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      out_ready = tbl[c].rdy;
      check("basic_valid", 64'(out_valid), 64'(tbl[c].vld));
      check("basic_addr", 64'(ram_addr), 64'(tbl[c].addr));
      check("basic_done", 64'(done), 64'(tbl[c].dn));
      check("basic_busy", 64'(busy), 64'(tbl[c].bsy));
      check("basic_we", 64'(ram_we), 64'd0);
      if (tbl[c].vld) begin
        check("basic_data", 64'(out_data), 64'(tbl[c].data));
      end
      tick();
    end

    // Zero length: one DRAIN cycle after the start edge, then done.
    num_rows = 12'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("zero_c0_busy", 64'(busy), 64'd1);
    check("zero_c0_done", 64'(done), 64'd0);
    check("zero_c0_valid", 64'(out_valid), 64'd0);
    tick();
    check("zero_c1_done", 64'(done), 64'd1);
    check("zero_c1_busy", 64'(busy), 64'd0);
    check("zero_c1_valid", 64'(out_valid), 64'd0);
    tick();
    check("zero_c2_done", 64'(done), 64'd0);
    check("zero_c2_valid", 64'(out_valid), 64'd0);

    // Stride with wrap: 0x7FE, 0x001, 0x004.
    run_cmd(11'h7FE, 11'd3, 12'd3, 2, 1'b0);
    // Backpressure pattern.
    run_cmd(11'h050, 11'd1, 12'd6, 1, 1'b0);
    // Start while busy is ignored.
    run_cmd(11'h020, 11'd2, 12'd5, 0, 1'b1);
    // Randomized commands with random ready.
    for (int k = 0; k < 8; k++) begin
      run_cmd(AW'($urandom_range(0, 2047)), AW'($urandom_range(0, 2047)),
              12'($urandom_range(0, 9)), 2, 1'b0);
    end

    // Reset after 2 of 8 words accepted.
    start_addr = 11'h100;
    stride     = 11'h001;
    num_rows   = 12'd8;
    out_ready  = 1'b1;
    start      = 1'b1;
    tick();
    start    = 1'b0;
    accepted = 0;
    for (int c = 0; c < 20 && accepted < 2; c++) begin
      if (out_valid && out_ready) begin
        accepted++;
      end
      tick();
    end
    check("rst_mid_accepted", 64'(accepted), 64'd2);
    reset = 1'b1;
    #1;
    check("rstm_addr", 64'(ram_addr), 64'd0);
    check("rstm_we", 64'(ram_we), 64'd0);
    check("rstm_data", 64'(out_data), 64'd0);
    check("rstm_valid", 64'(out_valid), 64'd0);
    check("rstm_busy", 64'(busy), 64'd0);
    check("rstm_done", 64'(done), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    run_cmd(11'h200, 11'd1, 12'd2, 0, 1'b0);
    tick();
    check("post_idle_valid", 64'(out_valid), 64'd0);
    check("post_idle_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
